// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one 4-bit magnitude comparator between two requesters.
// Fixed latency: request sampled in IDLE at edge N gives a one-cycle ack after edge N+3.
module cmp_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic [1:0] ack,
  output logic       a_gt_b,
  output logic       a_lt_b,
  output logic       a_eq_b,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {IDLE, LOAD, CMP, RESP} state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       grant_id_q, grant_id_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic       gt_q, gt_d;
  logic       lt_q, lt_d;
  logic       eq_q, eq_d;
  logic [1:0] ack_q, ack_d;
  logic       win_sel;
  logic       cmp_lt, cmp_gt, cmp_eq;

  Four_bit_Mag_Comperator u_cmp (
    .A_LT_B (cmp_lt),
    .A_GT_B (cmp_gt),
    .A_EQ_B (cmp_eq),
    .A      (op_a_q),
    .B      (op_b_q)
  );

  // Pointer only breaks ties; a lone requester always wins.
  assign win_sel = (req == 2'b11) ? ptr_q : req[1];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    gt_d       = gt_q;
    lt_d       = lt_q;
    eq_d       = eq_q;
    ack_d      = 2'b00;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_id_d = win_sel;
          ptr_d      = ~win_sel;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        op_a_d  = grant_id_q ? a1 : a0;
        op_b_d  = grant_id_q ? b1 : b0;
        state_d = CMP;
      end
      CMP: begin
        gt_d    = cmp_gt;
        lt_d    = cmp_lt;
        eq_d    = cmp_eq;
        state_d = RESP;
      end
      RESP: begin
        // Registered so the pulse lands in the cycle after leaving RESP.
        ack_d   = grant_id_q ? 2'b10 : 2'b01;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      grant_id_q <= 1'b0;
      op_a_q     <= 4'd0;
      op_b_q     <= 4'd0;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
      ack_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      gt_q       <= gt_d;
      lt_q       <= lt_d;
      eq_q       <= eq_d;
      ack_q      <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign a_gt_b   = gt_q;
  assign a_lt_b   = lt_q;
  assign a_eq_b   = eq_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;

endmodule

module Four_bit_Mag_Comperator (
  output logic       A_LT_B,
  output logic       A_GT_B,
  output logic       A_EQ_B,
  input  logic [3:0] A,
  input  logic [3:0] B
);
  assign A_LT_B = (A < B);
  assign A_GT_B = (A > B);
  assign A_EQ_B = (A == B);
endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: a spec-level model queues expected acks and results.
module tb_cmp_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic [1:0] ack;
  logic       a_gt_b, a_lt_b, a_eq_b, busy, grant_id;

  cmp_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a0       (a0),
    .b0       (b0),
    .a1       (a1),
    .b1       (b1),
    .ack      (ack),
    .a_gt_b   (a_gt_b),
    .a_lt_b   (a_lt_b),
    .a_eq_b   (a_eq_b),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ack;
    logic       gid;
    logic       gt;
    logic       lt;
    logic       eq;
    int         due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ack_cnt = 0;
  int   phase = 0;
  logic m_ptr = 1'b0;
  logic m_win = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Reference model: round-robin grant, operands captured one edge after grant.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      m_ptr = 1'b0;
      q.delete();
    end else begin
      exp_t e;
      logic [3:0] ea, eb;
      cyc++;
      case (phase)
        0: if (req != 2'b00) begin
             m_win = (req == 2'b11) ? m_ptr : req[1];
             m_ptr = ~m_win;
             phase = 1;
           end
        1: begin
             ea = m_win ? a1 : a0;
             eb = m_win ? b1 : b0;
             e.ack = m_win ? 2'b10 : 2'b01;
             e.gid = m_win;
             e.gt  = (ea > eb);
             e.lt  = (ea < eb);
             e.eq  = (ea == eb);
             e.due = cyc + 2;
             q.push_back(e);
             phase = 2;
           end
        2: phase = 3;
        default: phase = 0;
      endcase
    end
  end

  // Monitor: sample away from the active edge and pop the scoreboard on each ack.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, (phase != 0));
      chk("ack_onehot", (ack == 2'b11), 0);
      if (ack != 2'b00) begin
        ack_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_ack", ack, 2'b00);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack", ack, e.ack);
          chk("grant_id", grant_id, e.gid);
          chk("a_gt_b", a_gt_b, e.gt);
          chk("a_lt_b", a_lt_b, e.lt);
          chk("a_eq_b", a_eq_b, e.eq);
          chk("ack_cycle", cyc, e.due);
        end
      end else if (q.size() != 0 && q[0].due < cyc) begin
        chk("ack_missing", ack, q[0].ack);
        void'(q.pop_front());
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_ack", ack, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_gt", a_gt_b, 0);
    chk("rst_lt", a_lt_b, 0);
    chk("rst_eq", a_eq_b, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_acks(input int n);
    int start;
    start = ack_cnt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (ack_cnt - start >= n) break;
    end
    chk("ack_count", ack_cnt - start, n);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (phase == p) break;
    end
    chk("phase_reached", phase, p);
  endtask

  task automatic run_req(input logic [1:0] r, input int n);
    req = r;
    wait_acks(n);
    req = 2'b00;
  endtask

  initial begin
    int start;
    #3;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Equal operands on requester 0
    @(negedge clk);
    a0 = 4'd5; b0 = 4'd5;
    run_req(2'b01, 1);

    // Both requesting continuously from a fresh pointer: strict alternation
    do_reset();
    a0 = 4'd7; b0 = 4'd5; a1 = 4'd9; b1 = 4'd10;
    run_req(2'b11, 4);

    // Lone requester 1, then a tie must go to requester 0
    do_reset();
    a1 = 4'd15; b1 = 4'd14;
    run_req(2'b10, 1);
    a0 = 4'd1; b0 = 4'd2;
    run_req(2'b11, 1);

    // Operand change during CMP is ignored
    a0 = 4'd3; b0 = 4'd12;
    req = 2'b01;
    wait_phase(2);
    a0 = 4'd15;
    wait_acks(1);
    req = 2'b00;

    // Reset during CMP aborts the transaction
    a0 = 4'd9; b0 = 4'd4;
    req = 2'b01;
    wait_phase(2);
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    a0 = 4'd0; b0 = 4'd0;
    run_req(2'b01, 1);

    // Requester drops req right after the grant
    @(negedge clk);
    a0 = 4'd2; b0 = 4'd9;
    start = ack_cnt;
    req = 2'b01;
    wait_phase(1);
    req = 2'b00;
    repeat (10) @(negedge clk);
    chk("drop_single_ack", ack_cnt - start, 1);

    // Random operands and request patterns
    for (int i = 0; i < 16; i++) begin
      a0 = 4'($urandom_range(0, 15));
      b0 = 4'($urandom_range(0, 15));
      a1 = 4'($urandom_range(0, 15));
      b1 = 4'($urandom_range(0, 15));
      run_req(2'($urandom_range(1, 3)), 1);
    end

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
